led_blink_sequencer: RTL and testbench



---
 rtl/led_blink_sequencer.sv | 170 +++++++++++++++++
 tb/tb_led_blink_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_sequencer.sv
// Command-driven LED blink sequencer.
// Plays one on/off pattern per accepted command; count 0 repeats until abort.
module led_blink_sequencer #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_on_ticks,
    input  logic [15:0] cmd_off_ticks,
    input  logic [7:0]  cmd_count,
    input  logic        abort,
    output logic        led,
    output logic        busy,
    output logic        done,
    output logic [7:0]  remaining
);

    localparam int TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    generate
        if ((CLK_FREQ % TICK_HZ) != 0 || TICK_DIV < 2) begin : g_bad_div
            $error("led_blink_sequencer: CLK_FREQ/TICK_HZ must be an integer >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t        state_q, state_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          inf_q, inf_d;
    logic [7:0]    rem_q, rem_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   ph_q, ph_d;
    logic [15:0]   on_len_q, on_len_d;
    logic [15:0]   off_len_q, off_len_d;

    logic          tick;
    logic [15:0]   cur_len;
    logic [15:0]   ph_inc;
    logic          ph_end;
    logic          cyc_end;
    logic          last;

    always_comb begin
        tick    = busy_q && (pre_q == PW'(TICK_DIV - 1));
        cur_len = (state_q == S_ON) ? on_len_q : off_len_q;
        ph_inc  = ph_q + 16'd1;
        ph_end  = tick && (ph_inc == cur_len);
        // A cycle ends after OFF, or after ON when OFF is zero-length
        cyc_end = ph_end && ((state_q == S_OFF) || (off_len_q == 16'd0));
        last    = cyc_end && !inf_q && (rem_q == 8'd0);
    end

    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        inf_d     = inf_q;
        rem_d     = rem_q;
        pre_d     = pre_q;
        ph_d      = ph_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    on_len_d  = cmd_on_ticks;
                    off_len_d = cmd_off_ticks;
                    inf_d     = (cmd_count == 8'd0);
                    rem_d     = (cmd_count == 8'd0) ? 8'd0 : cmd_count - 8'd1;
                    pre_d     = '0;
                    ph_d      = '0;
                    if (cmd_on_ticks != 16'd0) begin
                        state_d = S_ON;
                        led_d   = 1'b1;
                        busy_d  = 1'b1;
                    end else if (cmd_off_ticks != 16'd0) begin
                        state_d = S_OFF;
                        led_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        rem_d  = 8'd0;
                        done_d = 1'b1;
                    end
                end
            end
            S_ON, S_OFF: begin
                pre_d = tick ? '0 : pre_q + 1'b1;
                if (tick) begin
                    ph_d = ph_inc;
                end
                if (last || abort) begin
                    state_d = S_IDLE;
                    led_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = last;
                    rem_d   = 8'd0;
                    pre_d   = '0;
                    ph_d    = '0;
                end else if (cyc_end) begin
                    ph_d = '0;
                    if (!inf_q) begin
                        rem_d = rem_q - 8'd1;
                    end
                    if (on_len_q != 16'd0) begin
                        state_d = S_ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = S_OFF;
                        led_d   = 1'b0;
                    end
                end else if (ph_end) begin
                    state_d = S_OFF;
                    led_d   = 1'b0;
                    ph_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                led_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            inf_q     <= 1'b0;
            rem_q     <= 8'd0;
            pre_q     <= '0;
            ph_q      <= 16'd0;
            on_len_q  <= 16'd0;
            off_len_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            inf_q     <= inf_d;
            rem_q     <= rem_d;
            pre_q     <= pre_d;
            ph_q      <= ph_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign led       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer.
// TICK_DIV = 10: every tick is 10 clocks.
module tb_led_blink_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] on_t = 16'd0;
    logic [15:0] off_t = 16'd0;
    logic [7:0]  cnt = 8'd0;
    logic        abort = 1'b0;
    logic        led;
    logic        busy;
    logic        done;
    logic [7:0]  remaining;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int d0;
    int b0;

    led_blink_sequencer #(
        .CLK_FREQ(100),
        .TICK_HZ (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_on_ticks (on_t),
        .cmd_off_ticks(off_t),
        .cmd_count    (cnt),
        .abort        (abort),
        .led          (led),
        .busy         (busy),
        .done         (done),
        .remaining    (remaining)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] on_v, input logic [15:0] off_v,
                        input logic [7:0] c_v);
        on_t      = on_v;
        off_t     = off_v;
        cnt       = c_v;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    // Counts cycles where led holds lvl over n clocks
    task automatic hold(input string tag, input logic lvl, input int n);
        int m = 0;
        for (int i = 0; i < n; i++) begin
            if (led === lvl) m++;
            step();
        end
        chk(tag, m, n);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rem", remaining, 0);
        reset = 1'b0;
        step();
        chk("rst_ready", cmd_ready, 1);

        // basic: on=2 off=3 count=2
        d0 = done_cnt;
        send(16'd2, 16'd3, 8'd2);
        chk("b_busy", busy, 1);
        chk("b_ready", cmd_ready, 0);
        chk("b_rem1", remaining, 1);
        hold("b_on1", 1'b1, 20);
        hold("b_off1", 1'b0, 30);
        chk("b_rem0", remaining, 0);
        hold("b_on2", 1'b1, 20);
        hold("b_off2", 1'b0, 29);
        chk("b_early", done, 0);
        step();
        chk("b_done", done, 1);
        chk("b_rdy2", cmd_ready, 1);
        chk("b_busy0", busy, 0);
        step();
        chk("b_pulse", done, 0);
        chk("b_ndone", done_cnt - d0, 1);

        // zero-length ON
        send(16'd0, 16'd4, 8'd1);
        chk("za_led", led, 0);
        chk("za_busy", busy, 1);
        hold("za_off", 1'b0, 39);
        chk("za_early", done, 0);
        step();
        chk("za_done", done, 1);
        step();

        // zero-length OFF
        send(16'd3, 16'd0, 8'd2);
        chk("zb_rem1", remaining, 1);
        hold("zb_on1", 1'b1, 30);
        chk("zb_rem0", remaining, 0);
        hold("zb_on2", 1'b1, 29);
        chk("zb_early", done, 0);
        step();
        chk("zb_done", done, 1);
        chk("zb_led", led, 0);
        step();

        // both zero
        b0 = busy_cnt;
        send(16'd0, 16'd0, 8'd3);
        chk("zc_done", done, 1);
        chk("zc_ready", cmd_ready, 1);
        chk("zc_led", led, 0);
        step();
        chk("zc_pulse", done, 0);
        chk("zc_nobusy", busy_cnt - b0, 0);

        // infinite mode plus abort
        d0 = done_cnt;
        send(16'd1, 16'd1, 8'd0);
        chk("inf_rem", remaining, 0);
        for (int k = 0; k < 10; k++) begin
            hold("inf_on", 1'b1, 10);
            hold("inf_off", 1'b0, 10);
        end
        chk("inf_rem2", remaining, 0);
        repeat (3) step();
        chk("inf_mid", led, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_led", led, 0);
        chk("ab_busy", busy, 0);
        chk("ab_ready", cmd_ready, 1);
        step();
        chk("ab_nodone", done_cnt - d0, 0);

        // handshake: busy holds off changing commands
        d0 = done_cnt;
        send(16'd2, 16'd1, 8'd1);
        cmd_valid = 1'b1;
        b0 = 0;
        for (int i = 0; i < 30; i++) begin
            logic e;
            e = (i < 20);
            on_t  = 16'(i + 5);
            off_t = 16'(i);
            cnt   = 8'(i);
            if (led !== e) b0++;
            step();
        end
        chk("hs_hold", b0, 0);
        chk("hs_done", done, 1);
        chk("hs_ready", cmd_ready, 1);
        on_t  = 16'd4;
        off_t = 16'd2;
        cnt   = 8'd1;
        step();
        cmd_valid = 1'b0;
        chk("hs_acc", led, 1);
        chk("hs_busy", busy, 1);
        hold("hs_on", 1'b1, 40);
        hold("hs_off", 1'b0, 19);
        step();
        chk("hs_done2", done, 1);
        step();
        chk("hs_ndone", done_cnt - d0, 2);

        // abort on completion edge
        send(16'd1, 16'd1, 8'd1);
        hold("ca_on", 1'b1, 10);
        hold("ca_off", 1'b0, 9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ca_done", done, 1);
        chk("ca_busy", busy, 0);
        step();

        // abort with cmd_valid in IDLE
        abort = 1'b1;
        send(16'd2, 16'd0, 8'd1);
        abort = 1'b0;
        chk("cb_led", led, 1);
        chk("cb_busy", busy, 1);
        hold("cb_on", 1'b1, 19);
        step();
        chk("cb_done", done, 1);
        step();

        // reset mid-ON
        d0 = done_cnt;
        send(16'd3, 16'd2, 8'd5);
        chk("r_rem4", remaining, 4);
        repeat (15) step();
        chk("r_on", led, 1);
        reset = 1'b1;
        step();
        chk("r_led", led, 0);
        chk("r_busy", busy, 0);
        chk("r_rem", remaining, 0);
        chk("r_done", done, 0);
        reset = 1'b0;
        step();
        chk("r_ready", cmd_ready, 1);
        chk("r_nodone", done_cnt - d0, 0);
        send(16'd1, 16'd1, 8'd1);
        hold("r2_on", 1'b1, 10);
        hold("r2_off", 1'b0, 9);
        step();
        chk("r2_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
